// File: rtl/cordic_seq_pkg.sv
// cordic_seq_pkg: shared types and constants for the CORDIC multiplier
// sequencer. Holds the sequencer state enum, the operand/product widths,
// the nominal multiplier iteration count and the result-entry struct.
package cordic_seq_pkg;

  localparam int OPW      = 8;   // operand width (x and z)
  localparam int PRODW    = 16;  // product width
  localparam int MUL_ITER = 16;  // start cycles a compliant multiplier needs

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // One result FIFO entry: timeout flag plus product.
  typedef struct packed {
    logic             err;
    logic [PRODW-1:0] y;
  } result_t;

endpackage

// File: rtl/cordic_seq_fifo.sv
// cordic_seq_fifo: synchronous result FIFO for the CORDIC sequencer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write strobe and entry
//   pop               read strobe (ignored when empty)
//   count             number of stored entries (0..DEPTH)
//   head              oldest entry, all zeros when empty
//   full, empty       occupancy flags
// DEPTH must be a power of two so the pointers wrap on their own.
import cordic_seq_pkg::*;

module cordic_seq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = PRODW + 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read after it has been written,
  // and the empty mask keeps stale contents off head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cordic_mul_sequencer.sv
// cordic_mul_sequencer: feeds operand pairs to the sequential approximate
// CORDIC multiplier and collects its products into a result FIFO.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_x/in_z  operand stream (signed x, Q1.7 z)
//   out_valid/out_ready          result stream handshake
//   out_y, out_err               FIFO head product and timeout flag
//   mul_start, mul_x, mul_z      multiplier start level and held operands
//   mul_y, mul_done              multiplier product and done level
//   busy                         sequencer is not IDLE
// Optional feature: define CORDIC_SEQ_TIMEOUT_EN to abort a run that sees no
// mul_done within TIMEOUT_CYCLES RUN cycles; it pushes {err=1, y=0} instead.
// Without the macro RUN waits indefinitely and out_err is tied to 0.
import cordic_seq_pkg::*;

module cordic_mul_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_x,
  input  logic [OPW-1:0]   in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] out_y,
  output logic             out_err,
  output logic             mul_start,
  output logic [OPW-1:0]   mul_x,
  output logic [OPW-1:0]   mul_z,
  input  logic [PRODW-1:0] mul_y,
  input  logic             mul_done,
  output logic             busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES <= MUL_ITER) begin : g_bad_params
    $error("cordic_mul_sequencer: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
  end

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int ENTRY_W = PRODW + 1;
`else
  localparam int ENTRY_W = PRODW;
`endif

  state_t             state;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               accept;
  logic               done_seen;
  logic               timed_out;
  logic               push;
  logic               pop;
  logic               in_ready_next;

  assign accept    = (state == IDLE) && in_valid && in_ready && !fifo_full;
  assign done_seen = (state == RUN) && mul_done;
  assign push      = done_seen || timed_out;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // in_ready for the next IDLE cycle: a slot is free once a pop lands, and no
  // push can happen outside RUN.
  assign in_ready_next = (fifo_count != CW'(FIFO_DEPTH)) || pop;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer;
  result_t       push_entry;
  result_t       head_entry;

  // timer counts completed RUN cycles; the last allowed one fires the abort.
  assign timed_out = (state == RUN) && !mul_done &&
                     (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      timer <= '0;
    else if (state == RUN && !push)  timer <= timer + TW'(1);
    else                             timer <= '0;
  end

  always_comb begin
    push_entry.err = timed_out;
    push_entry.y   = done_seen ? mul_y : '0;
  end

  assign push_data  = push_entry;
  assign head_entry = head;
  assign out_y      = head_entry.y;
  assign out_err    = head_entry.err;
`else
  assign timed_out = 1'b0;
  assign push_data = mul_y;
  assign out_y     = head;
  assign out_err   = 1'b0;
`endif

  cordic_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: in_ready is a register cleared by reset so it reads 0 while rst_n is
  // low, even though the state itself resets to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mul_start <= 1'b0;
      mul_x     <= '0;
      mul_z     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            mul_x     <= in_x;
            mul_z     <= in_z;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
          end else begin
            in_ready  <= in_ready_next;
          end
        end
        RUN: begin
          if (push) begin
            state     <= RECOVER;
            mul_start <= 1'b0;
          end
        end
        RECOVER: begin
          // One start-low cycle rewinds the multiplier to iteration zero.
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= in_ready_next;
        end
        default: begin
          state     <= IDLE;
          mul_start <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_mul_sequencer.sv
// Directed testbench for cordic_mul_sequencer with a behavioural multiplier
// stub that raises mul_done after stub_len start cycles (0 = never).
module tb_cordic_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_z = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;
  logic        out_err;
  logic        mul_start;
  logic [7:0]  mul_x;
  logic [7:0]  mul_z;
  logic [15:0] mul_y;
  logic        mul_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          stub_len = 16;
  logic [15:0] stub_y = '0;
  int          stub_cnt;

  cordic_mul_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err),
    .mul_start (mul_start),
    .mul_x     (mul_x),
    .mul_z     (mul_z),
    .mul_y     (mul_y),
    .mul_done  (mul_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Multiplier stub: counts start cycles, done is a level while start is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stub_cnt <= 0;
    else        stub_cnt <= mul_start ? stub_cnt + 1 : 0;
  end
  assign mul_done = mul_start && (stub_len != 0) && (stub_cnt >= stub_len - 1);
  assign mul_y    = stub_y;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one operand pair for one edge.
  // Returns just after the accept edge E0.
  task automatic accept(input logic [7:0] x, input logic [7:0] z);
    int n = 0;
    while (in_ready !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b expected 1", in_ready);
    end
    in_x = x; in_z = z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 80) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic run_op(input logic [15:0] y);
    stub_y = y;
    accept(8'd1, 8'd1);
    wait_idle();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_y !== 16'h0) begin errors++; $display("FAIL rst_out_y: got %h expected 0000", out_y); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err: got %b expected 0", out_err); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start: got %b expected 0", mul_start); end
    checks++; if ({mul_x, mul_z} !== 16'h0) begin errors++; $display("FAIL rst_mul_xz: got %h expected 0000", {mul_x, mul_z}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    stub_len = 16; stub_y = 16'h1234;
    accept(8'd10, 8'd64);  // now just after E0
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start_e0: got %b expected 1", mul_start); end
    checks++; if (mul_x !== 8'd10 || mul_z !== 8'd64) begin errors++; $display("FAIL single_operands: got %0d,%0d expected 10,64", mul_x, mul_z); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_run_flags: in_ready=%b busy=%b expected 0,1", in_ready, busy); end
    for (int e = 1; e <= 15; e++) begin
      tick();
      checks++;
      if (mul_start !== 1'b1 || out_valid !== 1'b0 || mul_x !== 8'd10) begin
        errors++;
        $display("FAIL single_run_e%0d: start=%b out_valid=%b mul_x=%0d expected 1,0,10", e, mul_start, out_valid, mul_x);
      end
    end
    tick();  // E16
    checks++; if (out_valid !== 1'b1 || out_y !== 16'h1234) begin errors++; $display("FAIL single_result: valid=%b y=%h expected 1,1234", out_valid, out_y); end
    checks++; if (mul_start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_recover: start=%b in_ready=%b busy=%b expected 0,0,1", mul_start, in_ready, busy); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", out_err); end
    tick();  // E17
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL single_idle: in_ready=%b busy=%b start=%b expected 1,0,0", in_ready, busy, mul_start); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_y !== 16'h0) begin errors++; $display("FAIL single_pop: valid=%b y=%h expected 0,0000", out_valid, out_y); end
  endtask

  task automatic test_backpressure();
    stub_len = 16;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) run_op(16'(i));
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL bp_no_accept: busy=%b start=%b expected 0,0", busy, mul_start); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_y !== 16'(i)) begin
        errors++;
        $display("FAIL bp_pop_%0d: valid=%b y=%h expected 1,%h", i, out_valid, out_y, 16'(i));
      end
      tick();
      if (i == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b expected 1", in_ready); end
      end
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_y [3];
    exp_y[0] = 16'hB002; exp_y[1] = 16'hC003; exp_y[2] = 16'hD004;
    stub_len = 16;
    out_ready = 1'b0;
    run_op(16'hA001);
    run_op(16'hB002);
    run_op(16'hC003);
    stub_y = 16'hD004;
    accept(8'd3, 8'd5);  // accepted with three entries stored
    for (int e = 1; e <= 15; e++) tick();
    out_ready = 1'b1;
    tick();  // E16: pop A and push D together
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_y !== 16'hB002) begin errors++; $display("FAIL simul_head: valid=%b y=%h expected 1,b002", out_valid, out_y); end
    tick();  // E17
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_y !== exp_y[i]) begin
        errors++;
        $display("FAIL simul_order_%0d: valid=%b y=%h expected 1,%h", i, out_valid, out_y, exp_y[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    stub_len = 16; stub_y = 16'h5555;
    accept(8'd7, 8'd9);
    for (int e = 1; e <= 8; e++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mul_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async: start=%b busy=%b expected 0,0", mul_start, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_after: valid=%b busy=%b in_ready=%b expected 0,0,1", out_valid, busy, in_ready); end
    for (int e = 0; e < 20; e++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_push: got %b expected 0", out_valid); end
  endtask

  task automatic test_late_done();
    stub_len = 20; stub_y = 16'hFEDC;
    accept(8'h80, 8'h7F);
    for (int e = 1; e <= 16; e++) tick();
    checks++; if (out_valid !== 1'b0 || mul_start !== 1'b1) begin errors++; $display("FAIL late_e16: valid=%b start=%b expected 0,1", out_valid, mul_start); end
    for (int e = 17; e <= 20; e++) tick();
    checks++; if (out_valid !== 1'b1 || out_y !== 16'hFEDC || out_err !== 1'b0) begin errors++; $display("FAIL late_result: valid=%b y=%h err=%b expected 1,fedc,0", out_valid, out_y, out_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_idle();
    stub_len = 16;
  endtask

`ifdef CORDIC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    stub_len = 0; stub_y = 16'hBEEF;
    accept(8'd2, 8'd2);
    for (int e = 1; e <= 31; e++) tick();
    checks++; if (out_valid !== 1'b0 || mul_start !== 1'b1) begin errors++; $display("FAIL to_e31: valid=%b start=%b expected 0,1", out_valid, mul_start); end
    tick();  // E32
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_y !== 16'h0) begin errors++; $display("FAIL to_result: valid=%b err=%b y=%h expected 1,1,0000", out_valid, out_err, out_y); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_idle();
    stub_len = 16;
    run_op(16'h0042);
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_y !== 16'h0042) begin errors++; $display("FAIL to_next_ok: valid=%b err=%b y=%h expected 1,0,0042", out_valid, out_err, out_y); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_run();
    test_late_done();
`ifdef CORDIC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
